// File: rtl/fifo_pixel_scanout.sv
// VGA scanout: pops one RGB444 word per active pixel and drives registered RGB/sync pins.
// Latency 2 cycles from counter position to pins; no backpressure, an empty FIFO blanks the pixel.
module fifo_pixel_scanout #(
  parameter int BUS_WIDTH   = 12,
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BUS_WIDTH-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start,
  output logic                 underflow,
  output logic [15:0]          underflow_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  // One spare bit so every window bound, including the total itself, fits.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_RUN        = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_last, v_last;
  logic          active, hs_win, vs_win;

  logic run, uf0, fs0;

  logic act1_q, act1_d;
  logic got1_q, got1_d;
  logic uf1_q, uf1_d;
  logic fs1_q, fs1_d;
  logic hs1_q, hs1_d;
  logic vs1_q, vs1_d;

  logic [BUS_WIDTH-1:0] rgb_q, rgb_d;
  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;
  logic                 fs_q, fs_d;
  logic                 uf_q, uf_d;
  logic [15:0]          cnt_q, cnt_d;

  always_comb begin
    h_last = (h_q == HW'(H_TOTAL - 1));
    v_last = (v_q == VW'(V_TOTAL - 1));
    h_d    = h_last ? '0 : h_q + HW'(1);
    v_d    = v_q;
    if (h_last) begin
      v_d = v_last ? '0 : v_q + VW'(1);
    end
  end

  always_comb begin
    active = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    hs_win = (h_q >= HW'(H_ACTIVE + H_FRONT)) && (h_q < HW'(H_ACTIVE + H_FRONT + H_SYNC));
    vs_win = (v_q >= VW'(V_ACTIVE + V_FRONT)) && (v_q < VW'(V_ACTIVE + V_FRONT + V_SYNC));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping enable wins from any state, in the same cycle.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:       state_d = ST_WAIT_FRAME;
        ST_WAIT_FRAME: if (h_last && v_last) state_d = ST_RUN;
        ST_RUN:        state_d = ST_RUN;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    run       = (state_q == ST_RUN) && enable && !reset;
    fifo_read = run && active && !fifo_empty;
    uf0       = run && active && fifo_empty;
    fs0       = run && (h_q == '0) && (v_q == '0);
  end

  always_comb begin
    act1_d = active;
    got1_d = fifo_read;
    uf1_d  = uf0;
    fs1_d  = fs0;
    hs1_d  = hs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs1_d  = vs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;

    // fifo_data is only meaningful in the cycle after a pop.
    rgb_d = (got1_q && act1_q) ? fifo_data : '0;
    hs_d  = hs1_q;
    vs_d  = vs1_q;
    fs_d  = fs1_q;
    uf_d  = uf1_q;
    cnt_d = (uf1_q && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      act1_q <= 1'b0;
      got1_q <= 1'b0;
      uf1_q  <= 1'b0;
      fs1_q  <= 1'b0;
      hs1_q  <= ~SYNC_ACTIVE;
      vs1_q  <= ~SYNC_ACTIVE;
      rgb_q  <= '0;
      hs_q   <= ~SYNC_ACTIVE;
      vs_q   <= ~SYNC_ACTIVE;
      fs_q   <= 1'b0;
      uf_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      act1_q <= act1_d;
      got1_q <= got1_d;
      uf1_q  <= uf1_d;
      fs1_q  <= fs1_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
      uf_q   <= uf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign red             = rgb_q[11:8];
  assign green           = rgb_q[7:4];
  assign blue            = rgb_q[3:0];
  assign hsync           = hs_q;
  assign vsync           = vs_q;
  assign frame_start     = fs_q;
  assign underflow       = uf_q;
  assign underflow_count = cnt_q;

endmodule

// File: tb/tb_fifo_pixel_scanout.sv
// Bench for fifo_pixel_scanout: small-frame scenarios against a per-cycle position model,
// plus a large-active-area instance driven into counter saturation.
module tb_fifo_pixel_scanout;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam int SHA = 100, SHT = 101;
  localparam int SVA = 40, SVT = 41;
  localparam int SF = SHT * SVT;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1, enable = 1'b0, fifo_empty = 1'b0;
  logic [11:0] fifo_data = 12'h000;
  logic        fifo_read, hsync, vsync, frame_start, underflow;
  logic [3:0]  red, green, blue;
  logic [15:0] underflow_count;

  fifo_pixel_scanout #(
    .BUS_WIDTH(12), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_read(fifo_read), .red(red), .green(green),
    .blue(blue), .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .underflow(underflow), .underflow_count(underflow_count)
  );

  logic        s_reset = 1'b1, s_enable = 1'b1, s_empty = 1'b1;
  logic [11:0] s_data = 12'h000;
  logic        s_read, s_hsync, s_vsync, s_fs, s_underflow;
  logic [3:0]  s_red, s_green, s_blue;
  logic [15:0] s_count;

  fifo_pixel_scanout #(
    .BUS_WIDTH(12), .H_ACTIVE(SHA), .H_FRONT(0), .H_SYNC(1), .H_BACK(0),
    .V_ACTIVE(SVA), .V_FRONT(0), .V_SYNC(1), .V_BACK(0), .SYNC_ACTIVE(1'b0)
  ) sat (
    .clock(clock), .reset(s_reset), .enable(s_enable), .fifo_data(s_data),
    .fifo_empty(s_empty), .fifo_read(s_read), .red(s_red), .green(s_green),
    .blue(s_blue), .hsync(s_hsync), .vsync(s_vsync), .frame_start(s_fs),
    .underflow(s_underflow), .underflow_count(s_count)
  );

  int sat_k = 0;
  always @(posedge clock) begin
    if (s_reset) sat_k <= 0;
    else         sat_k <= sat_k + 1;
  end

  int checks = 0, errors = 0;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs, vs, fs, uf;
    logic [15:0] cnt;
  } pin_t;

  localparam pin_t RST_PIN = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0, uf: 1'b0, cnt: 16'h0000};

  logic [11:0] words [0:1023];
  pin_t pipe [$];
  pin_t cur, exp_pin;
  int   m_n = 0, m_state = 0, m_idx = 0, rd_idx = 0, m_cnt = 0;
  int   pos_h = 0, pos_v = 0;
  logic exp_rd = 1'b0, dut_rd = 1'b0, act_now, run_now;

  // Model state 0/1/2: idle, waiting for frame end, scanning.
  task automatic sample();
    @(negedge clock);
    pos_h   = m_n % HT;
    pos_v   = (m_n / HT) % VT;
    act_now = (pos_h < HA) && (pos_v < VA);
    run_now = (m_state == 2) && enable && !reset;
    exp_rd  = run_now && act_now && !fifo_empty;
    cur.uf  = run_now && act_now && fifo_empty;
    cur.fs  = run_now && (pos_h == 0) && (pos_v == 0);
    cur.hs  = !((pos_h >= HA + HF) && (pos_h < HA + HF + HS));
    cur.vs  = !((pos_v >= VA + VF) && (pos_v < VA + VF + VS));
    cur.rgb = exp_rd ? words[m_idx] : 12'h000;
    cur.cnt = 16'h0000;
    exp_pin = pipe[0];
    dut_rd  = fifo_read;
  endtask

  task automatic advance();
    @(posedge clock);
    if (reset) begin
      m_n = 0; m_state = 0; m_cnt = 0;
      pipe.delete();
      pipe.push_back(RST_PIN);
      pipe.push_back(RST_PIN);
    end else begin
      if (cur.uf && m_cnt < 65535) m_cnt++;
      cur.cnt = m_cnt[15:0];
      void'(pipe.pop_front());
      pipe.push_back(cur);
      if (exp_rd) m_idx++;
      if (!enable) m_state = 0;
      else if (m_state == 0) m_state = 1;
      else if (m_state == 1 && pos_h == HT - 1 && pos_v == VT - 1) m_state = 2;
      m_n++;
    end
    #1;
    if (dut_rd === 1'b1) begin
      fifo_data = words[rd_idx];
      rd_idx++;
    end else begin
      fifo_data = 12'($urandom);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; fifo_empty = 1'b0;
    repeat (2) begin sample(); advance(); end
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) words[i] = 12'($urandom_range(1, 4095));
    m_idx = 0; rd_idx = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; fifo_empty = 1'b0;
    repeat (3) begin sample(); advance(); end
    sample();
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h want=000", {red, green, blue}); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL reset_sync got=%b%b want=11", hsync, vsync); end
    checks++; if (frame_start !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b want=00", frame_start, underflow); end
    checks++; if (underflow_count !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h want=0000", underflow_count); end
    checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_read got=%b want=0", fifo_read); end
    advance();
  endtask

  task automatic test_timing();
    int hs_low = 0, vs_low = 0, first_hs = -1;
    apply_reset();
    for (int c = 0; c < 96; c++) begin
      sample();
      checks++; if (hsync !== exp_pin.hs) begin errors++; $display("FAIL timing_hsync c=%0d got=%b want=%b", c, hsync, exp_pin.hs); end
      checks++; if (vsync !== exp_pin.vs) begin errors++; $display("FAIL timing_vsync c=%0d got=%b want=%b", c, vsync, exp_pin.vs); end
      checks++; if ({red, green, blue} !== 12'h000 || fifo_read !== 1'b0) begin errors++; $display("FAIL timing_blank c=%0d rgb=%h rd=%b want 000/0", c, {red, green, blue}, fifo_read); end
      if (hsync === 1'b0) begin hs_low++; if (first_hs < 0) first_hs = c; end
      if (vsync === 1'b0) vs_low++;
      advance();
    end
    checks++; if (first_hs !== 7) begin errors++; $display("FAIL timing_first_hsync got=%0d want=7", first_hs); end
    checks++; if (hs_low !== 23) begin errors++; $display("FAIL timing_hsync_count got=%0d want=23", hs_low); end
    checks++; if (vs_low !== 16) begin errors++; $display("FAIL timing_vsync_count got=%0d want=16", vs_low); end
  endtask

  task automatic test_frame_align();
    int first_rd = -1, first_fs = -1, reads2 = 0, reads3 = 0;
    apply_reset();
    for (int c = 0; c < 144; c++) begin
      if (c == 10) enable = 1'b1;
      sample();
      checks++; if (fifo_read !== exp_rd) begin errors++; $display("FAIL align_read c=%0d got=%b want=%b", c, fifo_read, exp_rd); end
      checks++; if (frame_start !== exp_pin.fs || {red, green, blue} !== exp_pin.rgb) begin errors++; $display("FAIL align_pins c=%0d fs=%b rgb=%h want fs=%b rgb=%h", c, frame_start, {red, green, blue}, exp_pin.fs, exp_pin.rgb); end
      if (fifo_read === 1'b1 && first_rd < 0) first_rd = c;
      if (frame_start === 1'b1 && first_fs < 0) first_fs = c;
      if (fifo_read === 1'b1 && c >= 48 && c < 96) reads2++;
      if (fifo_read === 1'b1 && c >= 96) reads3++;
      advance();
    end
    checks++; if (first_rd !== 48) begin errors++; $display("FAIL align_first_read got=%0d want=48", first_rd); end
    checks++; if (first_fs !== 50) begin errors++; $display("FAIL align_first_fs got=%0d want=50", first_fs); end
    checks++; if (reads2 !== 12 || reads3 !== 12) begin errors++; $display("FAIL align_reads got=%0d,%0d want=12,12", reads2, reads3); end
  endtask

  task automatic test_pixel_data();
    logic [11:0] tbl [0:7];
    tbl[0] = 12'hF00; tbl[1] = 12'h0F0; tbl[2] = 12'h00F; tbl[3] = 12'hABC;
    tbl[4] = 12'h000; tbl[5] = 12'h000; tbl[6] = 12'h000; tbl[7] = 12'h000;
    apply_reset();
    for (int i = 0; i < 4; i++) words[i] = tbl[i];
    enable = 1'b1;
    for (int c = 0; c < 64; c++) begin
      sample();
      checks++; if ({red, green, blue} !== exp_pin.rgb) begin errors++; $display("FAIL pixel_model c=%0d got=%h want=%h", c, {red, green, blue}, exp_pin.rgb); end
      if (c >= 50 && c < 58) begin
        checks++; if ({red, green, blue} !== tbl[c-50]) begin errors++; $display("FAIL pixel_line0 c=%0d got=%h want=%h", c, {red, green, blue}, tbl[c-50]); end
      end
      advance();
    end
  endtask

  task automatic test_underflow();
    int reads = 0;
    apply_reset();
    enable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      fifo_empty = (c == 58);
      sample();
      checks++; if ({red, green, blue} !== exp_pin.rgb || underflow !== exp_pin.uf || underflow_count !== exp_pin.cnt) begin errors++; $display("FAIL uf_model c=%0d rgb=%h uf=%b cnt=%0d want %h/%b/%0d", c, {red, green, blue}, underflow, underflow_count, exp_pin.rgb, exp_pin.uf, exp_pin.cnt); end
      if (c == 60) begin
        checks++; if ({red, green, blue} !== 12'h000 || underflow !== 1'b1 || underflow_count !== 16'd1) begin errors++; $display("FAIL uf_pixel rgb=%h uf=%b cnt=%0d want 000/1/1", {red, green, blue}, underflow, underflow_count); end
      end
      if (c == 59 || c == 61) begin
        checks++; if ({red, green, blue} === 12'h000 || underflow !== 1'b0) begin errors++; $display("FAIL uf_neighbour c=%0d rgb=%h uf=%b want nonzero/0", c, {red, green, blue}, underflow); end
      end
      if (fifo_read === 1'b1 && c >= 48 && c < 96) reads++;
      advance();
    end
    checks++; if (reads !== 11) begin errors++; $display("FAIL uf_reads got=%0d want=11", reads); end
    checks++; if (underflow_count !== 16'd1) begin errors++; $display("FAIL uf_count_end got=%0d want=1", underflow_count); end
  endtask

  task automatic test_disable_reset();
    apply_reset();
    for (int c = 0; c < 131; c++) begin
      enable     = !(c >= 57 && c < 70);
      fifo_empty = ($urandom_range(0, 3) == 0);
      reset      = (c == 115);
      sample();
      checks++; if (fifo_read !== exp_rd) begin errors++; $display("FAIL dis_read c=%0d got=%b want=%b", c, fifo_read, exp_rd); end
      checks++; if ({red, green, blue} !== exp_pin.rgb || hsync !== exp_pin.hs || vsync !== exp_pin.vs || frame_start !== exp_pin.fs || underflow !== exp_pin.uf || underflow_count !== exp_pin.cnt) begin
        errors++; $display("FAIL dis_pins c=%0d got %h %b%b%b%b %0d want %h %b%b%b%b %0d", c, {red, green, blue}, hsync, vsync, frame_start, underflow, underflow_count, exp_pin.rgb, exp_pin.hs, exp_pin.vs, exp_pin.fs, exp_pin.uf, exp_pin.cnt);
      end
      if (c == 57) begin
        checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL dis_read_drop got=%b want=0", fifo_read); end
      end
      if (c >= 59 && c < 98) begin
        checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL dis_blank c=%0d got=%h want=000", c, {red, green, blue}); end
      end
      if (c == 116 || c == 117) begin
        checks++; if ({red, green, blue} !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1 || frame_start !== 1'b0 || underflow !== 1'b0 || underflow_count !== 16'h0000) begin
          errors++; $display("FAIL midreset_values c=%0d got %h %b%b%b%b %0d", c, {red, green, blue}, hsync, vsync, frame_start, underflow, underflow_count);
        end
      end
      if (c == 123) begin
        checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL midreset_restart got=%b want=0", hsync); end
      end
      advance();
    end
    reset = 1'b0;
  endtask

  function automatic bit is_uf(int j);
    return (j >= SF) && ((j % SHT) < SHA) && (((j / SHT) % SVT) < SVA);
  endfunction

  task automatic test_saturation();
    int k, uf_total, extra;
    logic [15:0] exp_cnt;
    bit done;
    @(negedge clock);
    k = sat_k; uf_total = 0; extra = 0; done = 1'b0;
    for (int j = 0; j <= k - 2; j++) if (is_uf(j)) uf_total++;
    while (!done && k < 90000) begin
      @(negedge clock);
      k = sat_k;
      if (is_uf(k - 2)) uf_total++;
      exp_cnt = (uf_total > 65535) ? 16'hFFFF : uf_total[15:0];
      if (k % 64 == 0) begin
        checks++; if (s_count !== exp_cnt || s_underflow !== is_uf(k - 2) || s_read !== 1'b0) begin errors++; $display("FAIL sat_track k=%0d cnt=%0d uf=%b rd=%b want %0d/%b/0", k, s_count, s_underflow, s_read, exp_cnt, is_uf(k - 2)); end
      end
      if (k == 2 * SF + 2) begin
        checks++; if (s_count !== 16'd4001) begin errors++; $display("FAIL sat_one_frame got=%0d want=4001", s_count); end
      end
      if (uf_total >= 70000) extra++;
      if (extra == 200) begin
        checks++; if (s_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final got=%h want=FFFF", s_count); end
        checks++; if (s_underflow !== is_uf(k - 2)) begin errors++; $display("FAIL sat_pulse got=%b want=%b", s_underflow, is_uf(k - 2)); end
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL sat_timeout k=%0d underflows=%0d want>=70000", k, uf_total);
    end
  endtask

  initial begin
    pipe.push_back(RST_PIN);
    pipe.push_back(RST_PIN);
    for (int i = 0; i < 1024; i++) words[i] = 12'($urandom_range(1, 4095));
    repeat (2) @(posedge clock);
    #1 s_reset = 1'b0;
    test_reset();
    test_timing();
    test_frame_align();
    test_pixel_data();
    test_underflow();
    test_disable_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
